// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state codes,
// per-stage stall masks and the default exception entry vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'b00,
    CTRL_DRAIN = 2'b01,
    CTRL_FLUSH = 2'b10
  } ctrl_state_t;

  // Stall masks, bit 0 = pc register .. bit 5 = writeback; 1 = stop
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // ERET returns to the saved EPC, every other exception enters the vector
  function automatic logic [31:0] redirect_target(input logic        is_eret,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] vector);
    return is_eret ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder turning per-stage stall requests into a stall mask.
// A stalled stage must also hold every stage in front of it, so the
// deepest requesting stage decides the mask.
module stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] mask
);

  // Deepest requester wins; it freezes itself and everything upstream
  always_comb begin
    mask = STALL_NONE;
    if (req_mem)      mask = STALL_MEM;
    else if (req_ex)  mask = STALL_EX;
    else if (req_id)  mask = STALL_ID;
    else if (req_if)  mask = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests and sequences
// exception / ERET redirects. A redirect is held back (DRAIN) while an
// instruction or data bus transaction is outstanding so that no burst is
// cut short, then a single registered flush pulse carries new_pc.
// Optional feature macro: CTRL_STALL_PERF_EN adds saturating counters of
// stalled cycles and issued flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ibus_busy,
  input  logic              dbus_busy,
  input  logic              exc_valid,
  input  logic              exc_is_eret,
  input  logic [31:0]       cp0_epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc
`ifdef CTRL_STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  logic [31:0] target_q;
  logic [31:0] target_next;
  logic [5:0]  req_mask;
  logic        bus_busy;

  assign bus_busy = ibus_busy | dbus_busy;

  stall_encoder u_stall_encoder (
    .req_if  (stallreq_if),
    .req_id  (stallreq_id),
    .req_ex  (stallreq_ex),
    .req_mem (stallreq_mem),
    .mask    (req_mask)
  );

  // Next state, redirect target capture and the combinational stall mask
  always_comb begin
    state_next  = state;
    target_next = target_q;
    stall       = STALL_NONE;
    case (state)
      CTRL_RUN: begin
        if (exc_valid) begin
          stall       = STALL_ALL;
          target_next = redirect_target(exc_is_eret, cp0_epc, EXC_VECTOR);
          state_next  = bus_busy ? CTRL_DRAIN : CTRL_FLUSH;
        end else begin
          stall = req_mask;
        end
      end
      CTRL_DRAIN: begin
        stall = STALL_ALL;
        if (!bus_busy) state_next = CTRL_FLUSH;
      end
      CTRL_FLUSH: begin
        stall      = STALL_NONE;
        state_next = CTRL_RUN;
      end
      default: begin
        state_next = CTRL_RUN;
      end
    endcase
    if (rst) stall = STALL_NONE;
  end

  // State, captured target and the registered flush / new_pc outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CTRL_RUN;
      target_q <= 32'h0;
      flush    <= 1'b0;
      new_pc   <= 32'h0;
    end else begin
      state    <= state_next;
      target_q <= target_next;
      flush    <= (state_next == CTRL_FLUSH);
      new_pc   <= (state_next == CTRL_FLUSH) ? target_next : 32'h0;
    end
  end

`ifdef CTRL_STALL_PERF_EN
  // Saturating counters of stalled cycles and flush pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((stall != STALL_NONE) && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if ((state == CTRL_FLUSH) && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ibus_busy, dbus_busy;
  logic        exc_valid, exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
`ifdef CTRL_STALL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: a redirect is either waiting for the buses to go
  // quiet, or is being delivered as a flush this cycle.
  bit          m_pending = 0;
  bit          m_flush   = 0;
  logic [31:0] m_target  = 32'h0;
  logic [31:0] m_perf_stall = 32'h0;
  logic [31:0] m_perf_flush = 32'h0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(VEC), .PERF_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .ibus_busy    (ibus_busy),
    .dbus_busy    (dbus_busy),
    .exc_valid    (exc_valid),
    .exc_is_eret  (exc_is_eret),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc)
`ifdef CTRL_STALL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected stall: nothing under reset or during the flush cycle, all
  // stages while a redirect is pending or being raised, else the deepest
  // requesting stage and everything upstream of it.
  function automatic logic [5:0] modelStall(input bit r, input bit rif, input bit rid,
                                            input bit rex, input bit rmem, input bit exc);
    if (r || m_flush) return 6'b000000;
    if (m_pending || exc) return 6'b111111;
    if (rmem) return 6'b011111;
    if (rex)  return 6'b001111;
    if (rid)  return 6'b000111;
    if (rif)  return 6'b000011;
    return 6'b000000;
  endfunction

  // One clock: drive inputs at negedge, check stall, step model at posedge,
  // then check the registered outputs.
  task automatic applyStimulus(input string tag, input bit r, input bit rif, input bit rid,
                               input bit rex, input bit rmem, input bit ib, input bit db,
                               input bit exc, input bit eret, input logic [31:0] epc);
    logic [5:0] exp_stall;
    @(negedge clk);
    rst = r; stallreq_if = rif; stallreq_id = rid; stallreq_ex = rex; stallreq_mem = rmem;
    ibus_busy = ib; dbus_busy = db; exc_valid = exc; exc_is_eret = eret; cp0_epc = epc;
    #1;
    exp_stall = modelStall(r, rif, rid, rex, rmem, exc);
    checkOutput({tag, ":stall"}, {26'h0, stall}, {26'h0, exp_stall});
    @(posedge clk);
    if (r) begin
      m_pending = 0;
      m_flush = 0;
      m_perf_stall = 0;
      m_perf_flush = 0;
    end else begin
      if (exp_stall != 0) m_perf_stall++;
      if (m_flush) m_perf_flush++;
      if (m_flush) begin
        m_flush = 0;
      end else if (m_pending) begin
        if (!ib && !db) begin
          m_pending = 0;
          m_flush = 1;
        end
      end else if (exc) begin
        m_target = eret ? epc : VEC;
        if (ib || db) m_pending = 1;
        else m_flush = 1;
      end
    end
    #1;
    checkOutput({tag, ":flush"}, {31'h0, flush}, {31'h0, m_flush});
    checkOutput({tag, ":new_pc"}, new_pc, m_flush ? m_target : 32'h0);
`ifdef CTRL_STALL_PERF_EN
    checkOutput({tag, ":perf_stall"}, perf_stall_cyc, m_perf_stall);
    checkOutput({tag, ":perf_flush"}, perf_flush_cnt, m_perf_flush);
`endif
  endtask

  initial begin
    rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ibus_busy = 0; dbus_busy = 0; exc_valid = 0; exc_is_eret = 0; cp0_epc = 32'h0;

    // reset
    applyStimulus("reset0", 1, 1, 1, 1, 1, 0, 0, 1, 0, 32'h0);
    applyStimulus("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // stall priority, id+ex gives 001111
    applyStimulus("id_ex",  0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("if",     0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("mem",    0, 1, 1, 1, 1, 0, 0, 0, 0, 32'h0);

    // exception with idle buses: flush next cycle only
    applyStimulus("exc",    0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    applyStimulus("exc_fl", 0, 1, 0, 0, 1, 0, 0, 1, 0, 32'h0);
    applyStimulus("exc_af", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // ERET while dbus busy for three more cycles
    applyStimulus("eret",   0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h8000_1234);
    for (int i = 0; i < 3; i++)
      applyStimulus("drain", 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus("drain_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("eret_fl",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("eret_af",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // stall request plus exception: exception wins
    applyStimulus("mem_exc", 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h0);
    applyStimulus("mem_fl",  0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // reset during drain discards the pending redirect
    applyStimulus("pre_rst", 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h1234_5678);
    applyStimulus("drain2",  0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 59) == 0),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                    $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
